// File: rtl/netlist_mon_pkg.sv
// Shared types and MISR arithmetic for the netlist response monitor.
// Combinational helpers only; no state, no handshake.
// misr_next works on 32-bit containers so any SIG_W up to 32 shares one function.
package netlist_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

    // One MISR step of width w: shift left, fold the dropped MSB back through poly, xor in r.
    function automatic logic [31:0] misr_next(input logic [31:0] s,
                                              input logic [31:0] r,
                                              input logic [31:0] poly,
                                              input int          w);
        logic [31:0] mask;
        logic        fb;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        fb   = |(s & (32'h1 << (w - 1)));
        return ((s << 1) ^ (fb ? poly : 32'h0) ^ r) & mask;
    endfunction

endpackage

// File: rtl/monitor_trace_ram.sv
// Trace storage: DEPTH x W array, one write port, one registered read port.
// Read latency 1 cycle (old data on same-slot read/write); read register clears on reset.
// No backpressure; a write is taken on every cycle wr_en is high.
module monitor_trace_ram #(
    parameter int W     = 11,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          bertaClock,
    input  logic          global_reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge bertaClock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge bertaClock) begin
        if (global_reset)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/netlist_response_monitor.sv
// Response monitor: compacts sampled pads into a MISR, counts samples, checks against golden.
// Latency: done rises 2 edges after the final accepted sample; trace read (MONITOR_TRACE_EN) is 1 cycle.
// Backpressure: none; every sample_valid cycle in RUN is consumed, start is ignored outside IDLE/DONE.
module netlist_response_monitor
    import netlist_mon_pkg::*;
#(
    parameter int               RESP_W      = 11,
    parameter int               SIG_W       = 16,
    parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED        = SIG_W'(DEFAULT_SEED),
    parameter int               CNT_W       = 16,
    parameter int               TRACE_DEPTH = 8
) (
    input  logic              bertaClock,
    input  logic              global_reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  cycle_target,
    input  logic [SIG_W-1:0]  golden_sig,
    input  logic              sample_valid,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  cycle_count
`ifdef MONITOR_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_addr,
    output logic [RESP_W-1:0]              trace_data
`endif
);

    mon_state_t       state;
    logic [CNT_W-1:0] target_q;
    logic [SIG_W-1:0] sig_next;
    logic [CNT_W-1:0] count_inc;

    assign sig_next  = SIG_W'(misr_next(32'(signature), 32'(resp), 32'(POLY), SIG_W));
    assign count_inc = cycle_count + CNT_W'(1);
    assign busy      = (state == ST_RUN) || (state == ST_CHECK);
    assign done      = (state == ST_DONE);

    always_ff @(posedge bertaClock) begin
        if (global_reset) begin
            state       <= ST_IDLE;
            signature   <= SEED;
            cycle_count <= '0;
            pass        <= 1'b0;
            target_q    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        signature   <= SEED;
                        cycle_count <= '0;
                        pass        <= 1'b0;
                        target_q    <= cycle_target;
                        state       <= (cycle_target == '0) ? ST_CHECK : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sample_valid) begin
                        signature   <= sig_next;
                        cycle_count <= count_inc;
                        if (count_inc == target_q)
                            state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    pass  <= (signature == golden_sig);
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MONITOR_TRACE_EN
    localparam int TAW = $clog2(TRACE_DEPTH);

    logic [TAW-1:0] wr_ptr;
    logic           start_acc;
    logic           take;

    assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign take      = (state == ST_RUN) && sample_valid;

    // Power-of-two depth, so the pointer wraps on its own.
    always_ff @(posedge bertaClock) begin
        if (global_reset || start_acc)
            wr_ptr <= '0;
        else if (take)
            wr_ptr <= wr_ptr + TAW'(1);
    end

    monitor_trace_ram #(
        .W     (RESP_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .bertaClock   (bertaClock),
        .global_reset (global_reset),
        .wr_en        (take),
        .wr_addr      (wr_ptr),
        .wr_data      (resp),
        .rd_addr      (trace_addr),
        .rd_data      (trace_data)
    );
`endif

endmodule

// File: tb/tb_netlist_response_monitor.sv
// Scoreboard bench for netlist_response_monitor; trace scenario runs when MONITOR_TRACE_EN is defined.
module tb_netlist_response_monitor;

    logic        bertaClock = 1'b0;
    logic        global_reset;
    logic        start;
    logic [15:0] cycle_target;
    logic [15:0] golden_sig;
    logic        sample_valid;
    logic [10:0] resp;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [15:0] cycle_count;
`ifdef MONITOR_TRACE_EN
    logic [2:0]  trace_addr;
    logic [10:0] trace_data;
`endif

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 bertaClock = ~bertaClock;

    netlist_response_monitor dut (
        .bertaClock   (bertaClock),
        .global_reset (global_reset),
        .start        (start),
        .cycle_target (cycle_target),
        .golden_sig   (golden_sig),
        .sample_valid (sample_valid),
        .resp         (resp),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .cycle_count  (cycle_count)
`ifdef MONITOR_TRACE_EN
        ,
        .trace_addr   (trace_addr),
        .trace_data   (trace_data)
`endif
    );

    function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [10:0] r);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        return n ^ {5'b0, r};
    endfunction

    task automatic tick();
        @(posedge bertaClock);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        for (int i = 0; i < 50; i++) begin
            if (done) break;
            tick();
        end
        ok = done;
    endtask

    task automatic test_reset();
        global_reset = 1'b1;
        start = 1'b0; cycle_target = '0; golden_sig = '0; sample_valid = 1'b0; resp = '0;
`ifdef MONITOR_TRACE_EN
        trace_addr = '0;
`endif
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
        checks++; if (signature !== 16'hFFFF) begin errors++; $display("FAIL reset_sig got %h want ffff", signature); end
        checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cycle_count); end
`ifdef MONITOR_TRACE_EN
        checks++; if (trace_data !== 11'd0) begin errors++; $display("FAIL reset_trace got %h want 0", trace_data); end
`endif
        global_reset = 1'b0;
    endtask

    task automatic test_target_zero();
        exp_t e;
        start = 1'b1; cycle_target = 16'd0; golden_sig = 16'hFFFF;
        sb.push_back('{sig: 16'hFFFF, pass: 1'b1, cnt: 16'd0});
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL t0_edge1 busy/done got %b%b want 10", busy, done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL t0_edge2_done got %b want 1", done); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL t0_scoreboard empty"); end
        else begin
            e = sb.pop_front();
            checks++; if (pass !== e.pass) begin errors++; $display("FAIL t0_pass got %b want %b", pass, e.pass); end
            checks++; if (signature !== e.sig) begin errors++; $display("FAIL t0_sig got %h want %h", signature, e.sig); end
            checks++; if (cycle_count !== e.cnt) begin errors++; $display("FAIL t0_count got %0d want %0d", cycle_count, e.cnt); end
        end
    endtask

    task automatic test_single_sample();
        logic [15:0] goldens [2] = '{16'hEFDF, 16'h0000};
        logic [15:0] msig;
        exp_t e;
        bit ok;
        for (int run = 0; run < 2; run++) begin
            start = 1'b1; cycle_target = 16'd1; golden_sig = goldens[run];
            tick();
            start = 1'b0; sample_valid = 1'b1; resp = 11'd0;
            msig = model_misr(16'hFFFF, 11'd0);
            sb.push_back('{sig: msig, pass: (msig == goldens[run]), cnt: 16'd1});
            tick();
            sample_valid = 1'b0;
            checks++; if (signature !== 16'hEFDF) begin errors++; $display("FAIL single_sig_after_sample got %h want efdf", signature); end
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL single_timeout done got %b want 1", done); end
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL single_scoreboard empty"); end
            else begin
                e = sb.pop_front();
                checks++; if (pass !== e.pass) begin errors++; $display("FAIL single_pass run %0d got %b want %b", run, pass, e.pass); end
                checks++; if (signature !== e.sig) begin errors++; $display("FAIL single_sig got %h want %h", signature, e.sig); end
                checks++; if (cycle_count !== e.cnt) begin errors++; $display("FAIL single_count got %0d want %0d", cycle_count, e.cnt); end
            end
        end
    endtask

    task automatic test_valid_pattern();
        bit [5:0]    pat = 6'b101001;
        int          exp_cnt [6] = '{1, 1, 1, 2, 2, 3};
        logic [15:0] msig = 16'hFFFF;
        exp_t e;
        start = 1'b1; cycle_target = 16'd3;
        tick();
        for (int i = 0; i < 6; i++) begin
            sample_valid = pat[i];
            start        = !pat[i];
            resp         = 11'($urandom_range(0, 2047));
            if (pat[i]) msig = model_misr(msig, resp);
            tick();
            checks++; if (cycle_count !== 16'(exp_cnt[i])) begin errors++; $display("FAIL pattern_count step %0d got %0d want %0d", i, cycle_count, exp_cnt[i]); end
        end
        sample_valid = 1'b0; start = 1'b0; golden_sig = msig;
        sb.push_back('{sig: msig, pass: 1'b1, cnt: 16'd3});
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pattern_edge1 busy/done got %b%b want 10", busy, done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pattern_edge2_done got %b want 1", done); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL pattern_scoreboard empty"); end
        else begin
            e = sb.pop_front();
            checks++; if (pass !== e.pass) begin errors++; $display("FAIL pattern_pass got %b want %b", pass, e.pass); end
            checks++; if (signature !== e.sig) begin errors++; $display("FAIL pattern_sig got %h want %h", signature, e.sig); end
            checks++; if (cycle_count !== e.cnt) begin errors++; $display("FAIL pattern_count_final got %0d want %0d", cycle_count, e.cnt); end
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; cycle_target = 16'd5;
        tick();
        start = 1'b0; sample_valid = 1'b1;
        resp = 11'h2A5; tick();
        resp = 11'h15A; tick();
        sample_valid = 1'b0;
        checks++; if (cycle_count !== 16'd2) begin errors++; $display("FAIL midrun_count got %0d want 2", cycle_count); end
        global_reset = 1'b1;
        tick();
        global_reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrun_done got %b want 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL midrun_pass got %b want 0", pass); end
        checks++; if (signature !== 16'hFFFF) begin errors++; $display("FAIL midrun_sig got %h want ffff", signature); end
        checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL midrun_cnt got %0d want 0", cycle_count); end
        sample_valid = 1'b1; resp = 11'h7FF;
        tick();
        sample_valid = 1'b0;
        checks++; if (cycle_count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ignores_sample count %0d busy %b want 0 0", cycle_count, busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] msig;
        exp_t e;
        bit ok;
        for (int run = 0; run < 2; run++) begin
            start = 1'b1; cycle_target = 16'd2;
            tick();
            start = 1'b0; sample_valid = 1'b1;
            msig = 16'hFFFF;
            for (int k = 0; k < 2; k++) begin
                resp = 11'($urandom_range(0, 2047));
                msig = model_misr(msig, resp);
                tick();
            end
            sample_valid = 1'b0;
            golden_sig = (run == 0) ? msig : ~msig;
            sb.push_back('{sig: msig, pass: (run == 0), cnt: 16'd2});
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout run %0d done got %b want 1", run, done); end
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL b2b_scoreboard empty"); end
            else begin
                e = sb.pop_front();
                checks++; if (pass !== e.pass) begin errors++; $display("FAIL b2b_pass run %0d got %b want %b", run, pass, e.pass); end
                checks++; if (signature !== e.sig) begin errors++; $display("FAIL b2b_sig run %0d got %h want %h", run, signature, e.sig); end
                checks++; if (cycle_count !== e.cnt) begin errors++; $display("FAIL b2b_count run %0d got %0d want %0d", run, cycle_count, e.cnt); end
            end
        end
    endtask

`ifdef MONITOR_TRACE_EN
    task automatic test_trace();
        logic [10:0] tr [8];
        logic [2:0]  addrs [3] = '{3'd0, 3'd1, 3'd2};
        for (int i = 0; i < 8; i++) tr[i] = '0;
        start = 1'b1; cycle_target = 16'd10;
        tick();
        start = 1'b0;
        for (int v = 1; v <= 10; v++) begin
            sample_valid = 1'b1; resp = 11'(v);
            tr[(v - 1) % 8] = 11'(v);
            tick();
        end
        sample_valid = 1'b0;
        for (int a = 0; a < 3; a++) begin
            trace_addr = addrs[a];
            tick();
            checks++; if (trace_data !== tr[addrs[a]]) begin errors++; $display("FAIL trace_slot%0d got %0d want %0d", addrs[a], trace_data, tr[addrs[a]]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_target_zero();
        test_single_sample();
        test_valid_pattern();
        test_reset_mid_run();
        test_back_to_back();
`ifdef MONITOR_TRACE_EN
        test_trace();
`endif
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
